// File: rtl/aes_inv_round.sv
// Iterative AES decrypt round: InvShiftRows, AddRoundKey, then InvMixColumns one column per cycle.
// Define AES_INV_ROUND_PARALLEL_EN to mix all four columns in a single cycle instead.
module aes_inv_round #(
  parameter int NCOL  = 4,
  parameter int CNT_W = 2
) (
  input  logic         iClk,
  input  logic         iRst,
  input  logic         iValid,
  output logic         oReady,
  input  logic [0:127] iState,
  input  logic [0:127] iRoundKey,
  input  logic         iLast,
  output logic         oValid,
  input  logic         iReady,
  output logic [0:127] oState,
  output logic         oBusy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MIX  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]   state_q, state_d;
  logic [0:127] st_q, st_d;
`ifndef AES_INV_ROUND_PARALLEL_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  // Column packed MSB-first: bits [31:24] hold row 0.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a  [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    logic [31:0] res;
    res = '0;
    for (int r = 0; r < 4; r++) begin
      a[r]  = col[31-8*r -: 8];
      x2    = xtime(a[r]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[r] = x8 ^ a[r];
      mb[r] = x8 ^ x2 ^ a[r];
      md[r] = x8 ^ x4 ^ a[r];
      me[r] = x8 ^ x4 ^ x2;
    end
    for (int r = 0; r < 4; r++) begin
      res[31-8*r -: 8] = me[r] ^ mb[(r+1)%4] ^ md[(r+2)%4] ^ m9[(r+3)%4];
    end
    return res;
  endfunction

  // Row r rotates right by r; byte index is row + 4*col.
  function automatic logic [0:127] inv_shift_rows(input logic [0:127] s);
    logic [0:127] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[8*(r+4*c) +: 8] = s[8*(r+4*((c-r+4)%4)) +: 8];
      end
    end
    return o;
  endfunction

  always_comb begin
    state_d = state_q;
    st_d    = st_q;
`ifndef AES_INV_ROUND_PARALLEL_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (iValid) begin
          st_d    = inv_shift_rows(iState) ^ iRoundKey;
          state_d = iLast ? S_DONE : S_MIX;
`ifndef AES_INV_ROUND_PARALLEL_EN
          cnt_d   = '0;
`endif
        end
      end
      S_MIX: begin
`ifdef AES_INV_ROUND_PARALLEL_EN
        for (int c = 0; c < NCOL; c++) begin
          st_d[32*c +: 32] = inv_mix_col(st_q[32*c +: 32]);
        end
        state_d = S_DONE;
`else
        st_d[{cnt_q, 5'b0} +: 32] = inv_mix_col(st_q[{cnt_q, 5'b0} +: 32]);
        if (cnt_q == CNT_W'(NCOL-1)) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      S_DONE: begin
        if (iReady) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= S_IDLE;
      st_q    <= '0;
`ifndef AES_INV_ROUND_PARALLEL_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
`ifndef AES_INV_ROUND_PARALLEL_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Result register doubles as the working state; it only changes again on the next accept.
  assign oState = st_q;
  assign oValid = (state_q == S_DONE);
  assign oReady = (state_q == S_IDLE);
  assign oBusy  = (state_q != S_IDLE);

endmodule
